// File: rtl/regfile_scoreboard_if.sv
// Register-file port bundle: writeback, issue-claim and two read ports.
// Latency: none of its own; pure signal grouping.
// Backpressure: none; every field is sampled or driven each cycle.
interface regfile_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            RegWrite;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] write_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] read_data1;
  logic [XLEN-1:0] read_data2;
  logic            busy1;
  logic            busy2;
  logic [AW:0]     busy_count;

  // Pipeline side: issues claims, writes back, reads operands.
  modport master (
    output RegWrite, rd, write_data, issue_valid, issue_rd, rs1, rs2,
    input  read_data1, read_data2, busy1, busy2, busy_count
  );

  // Register file side.
  modport slave (
    input  RegWrite, rd, write_data, issue_valid, issue_rd, rs1, rs2,
    output read_data1, read_data2, busy1, busy2, busy_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending (scoreboard) bits and a live pending count.
// Latency: reads and busy flags are combinational; writes/claims land on the rising edge.
// Backpressure: none; optional macro REGFILE_BYPASS_EN forwards same-cycle writeback to reads.
module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);

  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [XLEN-1:0] r_data [NREG];
  logic [NREG-1:0] r_pend;
  logic [AW:0]     r_busy_count;

  logic            w_wr_en;
  logic            w_iss_en;
  logic            w_set;
  logic            w_clr;
  logic [AW:0]     w_cnt_next;

  // x0 is never a legal target for either a write or a claim.
  assign w_wr_en  = bus.RegWrite    && (bus.rd       != '0);
  assign w_iss_en = bus.issue_valid && (bus.issue_rd != '0);

  // A claim only counts if the bit was clear; a writeback only counts if the
  // bit was set and the same register is not being re-claimed this edge.
  assign w_set = w_iss_en && !r_pend[bus.issue_rd];
  assign w_clr = w_wr_en && r_pend[bus.rd] && !(w_iss_en && (bus.issue_rd == bus.rd));

  // Incremental popcount update: +1, -1 or unchanged.
  always_comb begin
    w_cnt_next = r_busy_count;
    if (w_set && !w_clr) begin
      w_cnt_next = r_busy_count + CNT_ONE;
    end else if (w_clr && !w_set) begin
      w_cnt_next = r_busy_count - CNT_ONE;
    end
  end

  // Data, pending bits and count; reset wins over writes and claims.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_data[i] <= '0;
      end
      r_pend       <= '0;
      r_busy_count <= '0;
    end else begin
      if (w_wr_en) begin
        r_data[bus.rd] <= bus.write_data;
      end
      for (int i = 1; i < NREG; i++) begin
        if (w_iss_en && (bus.issue_rd == AW'(i))) begin
          r_pend[i] <= 1'b1;
        end else if (w_wr_en && (bus.rd == AW'(i))) begin
          r_pend[i] <= 1'b0;
        end
      end
      r_busy_count <= w_cnt_next;
    end
  end

  // Read ports and busy flags, optionally forwarding the in-flight writeback.
  always_comb begin
    bus.read_data1 = (bus.rs1 == '0) ? '0 : r_data[bus.rs1];
    bus.read_data2 = (bus.rs2 == '0) ? '0 : r_data[bus.rs2];
    bus.busy1      = r_pend[bus.rs1];
    bus.busy2      = r_pend[bus.rs2];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_en && (bus.rs1 == bus.rd)) begin
      bus.read_data1 = bus.write_data;
      bus.busy1      = w_iss_en && (bus.issue_rd == bus.rs1);
    end
    if (w_wr_en && (bus.rs2 == bus.rd)) begin
      bus.read_data2 = bus.write_data;
      bus.busy2      = w_iss_en && (bus.issue_rd == bus.rs2);
    end
`endif
  end

  assign bus.busy_count = r_busy_count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vectors, expectations queued, negedge monitor compares.
// Latency: each queued expectation is checked at the negedge of the cycle it was issued in.
// Backpressure: none; at most one expectation is queued per cycle.
module tb_regfile_scoreboard;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk;
  logic rst;

  regfile_scoreboard_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s.%s: got %08h expected %08h", name, field, act, want);
    end
  endtask

  // Monitor: read ports are combinational, so sample mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "read_data1", bus.read_data1, e.rd1);
      chk(e.name, "read_data2", bus.read_data2, e.rd2);
      chk(e.name, "busy1", {31'd0, bus.busy1}, {31'd0, e.b1});
      chk(e.name, "busy2", {31'd0, bus.busy2}, {31'd0, e.b2});
      chk(e.name, "busy_count", {26'd0, bus.busy_count}, e.cnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.RegWrite    = 1'b0;
    bus.rd          = '0;
    bus.write_data  = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    bus.RegWrite   = 1'b1;
    bus.rd         = r;
    bus.write_data = d;
  endtask

  task automatic iss(input logic [4:0] r);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = r;
  endtask

  task automatic expect_rd(input string name, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic b1, input logic b2, input int cnt);
    exp_t e;
    bus.rs1 = a1;
    bus.rs2 = a2;
    e.name = name; e.rd1 = d1; e.rd2 = d2; e.b1 = b1; e.b2 = b2; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    int wait_cyc;
    rst = 1'b1;
    idle();
    bus.rs1 = '0;
    bus.rs2 = '0;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    expect_rd("reset", 5'd5, 5'd10, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    cyc();

    // Basic writes then reads
    wr(5'd5, 32'hDEADBEEF); cyc();
    wr(5'd10, 32'hCAFEBABE); cyc();
    idle();
    expect_rd("rw_basic", 5'd5, 5'd10, 32'hDEADBEEF, 32'hCAFEBABE, 1'b0, 1'b0, 0);
    cyc();

    // x0 is hardwired zero and never pending
    wr(5'd0, 32'hFFFFFFFF); iss(5'd0); cyc();
    idle();
    expect_rd("x0_zero", 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    cyc();

    // Issue x3, x7, then write back x3
    iss(5'd3); cyc(); idle();
    expect_rd("issue_x3", 5'd3, 5'd7, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    cyc();
    iss(5'd7); cyc(); idle();
    expect_rd("issue_x7", 5'd3, 5'd7, 32'h0, 32'h0, 1'b1, 1'b1, 2);
    cyc();
    wr(5'd3, 32'h00000011); cyc(); idle();
    expect_rd("wb_x3", 5'd3, 5'd7, 32'h00000011, 32'h0, 1'b0, 1'b1, 1);
    cyc();

    // Retire x7, then same-cycle claim and write of x4: set wins
    wr(5'd7, 32'h00000077); cyc(); idle();
    iss(5'd4); wr(5'd4, 32'h12345678); cyc(); idle();
    expect_rd("set_prio", 5'd4, 5'd7, 32'h12345678, 32'h00000077, 1'b1, 1'b0, 1);
    cyc();

    // Re-claim pending x4 and write back non-pending x7: count unchanged
    iss(5'd4); wr(5'd7, 32'h00000088); cyc(); idle();
    expect_rd("reissue_nounder", 5'd4, 5'd7, 32'h12345678, 32'h00000088, 1'b1, 1'b0, 1);
    cyc();

    // Claim x8 while retiring x4 in the same edge: +1 and -1 cancel
    iss(5'd8); wr(5'd4, 32'h00000044); cyc(); idle();
    expect_rd("set_clr_diff", 5'd4, 5'd8, 32'h00000044, 32'h0, 1'b0, 1'b1, 1);
    cyc();

    // Same-cycle write visibility on x9 (pending beforehand)
    iss(5'd9); wr(5'd9, 32'h00000099); cyc(); idle();
    wr(5'd9, 32'hA5A5A5A5);
`ifdef REGFILE_BYPASS_EN
    expect_rd("bypass_pre", 5'd9, 5'd8, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, 2);
`else
    expect_rd("bypass_pre", 5'd9, 5'd8, 32'h00000099, 32'h0, 1'b1, 1'b1, 2);
`endif
    cyc(); idle();
    expect_rd("bypass_post", 5'd9, 5'd8, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, 1);
    cyc();

    // Same-cycle write plus re-claim of x9: forwarded data, still busy
    wr(5'd9, 32'h5A5A5A5A); iss(5'd9);
`ifdef REGFILE_BYPASS_EN
    expect_rd("bypass_iss_pre", 5'd9, 5'd8, 32'h5A5A5A5A, 32'h0, 1'b1, 1'b1, 1);
`else
    expect_rd("bypass_iss_pre", 5'd9, 5'd8, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, 1);
`endif
    cyc(); idle();
    expect_rd("bypass_iss_post", 5'd9, 5'd8, 32'h5A5A5A5A, 32'h0, 1'b1, 1'b1, 2);
    cyc();

    // Claims in flight, then a reset that also sees a write and a claim
    iss(5'd2); cyc(); idle();
    iss(5'd6); cyc(); idle();
    wr(5'd6, 32'h00000001); cyc(); idle();
    expect_rd("pre_reset", 5'd6, 5'd2, 32'h00000001, 32'h0, 1'b0, 1'b1, 3);
    cyc();
    rst = 1'b1;
    wr(5'd6, 32'hFFFF0000); iss(5'd5);
    cyc();
    rst = 1'b0;
    idle();
    expect_rd("post_reset_a", 5'd6, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    cyc();
    expect_rd("post_reset_b", 5'd5, 5'd10, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    cyc();
    expect_rd("post_reset_c", 5'd9, 5'd3, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    cyc();

    // Drain the scoreboard with a bounded wait
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      cyc();
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits.
REQ-002 SHALL have parameter NREG, default 32: number of architectural registers, power of two, 2..64.
REQ-003 SHALL have parameter AW, default 5: register address width; AW = log2(NREG).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port RegWrite  input  1  writeback enable.
REQ-007 SHALL have port rd  input  AW  writeback destination register.
REQ-008 SHALL have port write_data  input  XLEN  writeback data.
REQ-009 SHALL have port issue_valid  input  1  marks issue_rd pending.
REQ-010 SHALL have port issue_rd  input  AW  register being claimed by an issued instruction.
REQ-011 SHALL have ports rs1 and rs2  input  AW each  read addresses.
REQ-012 SHALL have ports read_data1 and read_data2  output  XLEN each  read data.
REQ-013 SHALL have ports busy1 and busy2  output  1 each  pending flag of rs1 and rs2.
REQ-014 SHALL have port busy_count  output  AW+1  number of registers currently pending.

Function
REQ-015 SHALL hold NREG x XLEN data registers and NREG pending bits.
REQ-016 SHALL write write_data into register rd on a rising edge when RegWrite=1 and rd!=0.
REQ-017 SHALL treat register 0 as hardwired zero: writes ignored, read returns 0, pending bit never set.
REQ-018 SHALL drive read_data1/2 combinationally from the addressed register: zero-cycle read latency.
REQ-019 SHALL drive busy1/busy2 combinationally from the pending bits of rs1/rs2.
REQ-020 SHALL set pending[issue_rd] on an edge when issue_valid=1 and issue_rd!=0.
REQ-021 SHALL clear pending[rd] on an edge when RegWrite=1 and rd!=0.
REQ-022 SHALL give the set priority when issue_valid=1, RegWrite=1 and issue_rd==rd!=0: register is written and pending stays 1.
REQ-023 SHALL keep the pending bit at 1 when an already-pending register is issued again; busy_count SHALL NOT change.
REQ-024 SHALL leave the pending bit at 0 when a non-pending register is written back; busy_count SHALL NOT underflow.
REQ-025 SHALL keep busy_count equal to the population count of the pending bits every cycle, updated by +1, -1 or 0 per edge (never exceeding NREG-1).
REQ-026 SHALL hold the data of a register indefinitely when no write targets it.

Reset
REQ-027 SHALL clear every data register to 0 and every pending bit to 0 on an edge with rst=1.
REQ-028 SHALL give rst priority over RegWrite and issue_valid in the same cycle.
REQ-029 SHALL abandon in-flight claims on a mid-operation reset: after it, busy1=busy2=0, busy_count=0 and read_data1=read_data2=0 for every address.

Configuration
REQ-030 SHALL support macro REGFILE_BYPASS_EN.
REQ-031 With REGFILE_BYPASS_EN defined, a read whose address equals rd while RegWrite=1 and rd!=0 SHALL return write_data in that same cycle, and the matching busy output SHALL read 0 unless issue_valid=1 with issue_rd equal to the same address.
REQ-032 Without REGFILE_BYPASS_EN, reads SHALL return the stored value only; a same-cycle write becomes visible the cycle after the edge, and busy outputs reflect stored pending bits only.

Verification
REQ-033 Reset, then write x5=DEADBEEF and x10=CAFEBABE, then read rs1=5 and rs2=10 -> read_data1=DEADBEEF and read_data2=CAFEBABE.
REQ-034 Write x0=FFFFFFFF and issue_rd=0 -> read of x0 returns 00000000, busy1=0, busy_count=0.
REQ-035 Issue x3, then issue x7, then write back x3=00000011 -> busy_count goes 1, 2, 1; busy for x3=0; busy for x7=1; x3 reads 00000011.
REQ-036 Same cycle: issue_rd=4, rd=4, RegWrite=1, write_data=12345678 -> next cycle x4 reads 12345678, busy=1, busy_count=1.
REQ-037 With REGFILE_BYPASS_EN, rs1=9, RegWrite=1, rd=9, write_data=A5A5A5A5 -> read_data1=A5A5A5A5 before the edge; without the macro -> old value before the edge, A5A5A5A5 after it.
REQ-038 Issue x2, x6 and write x6=00000001, then assert rst for one cycle -> busy_count=0, busy1=busy2=0, and x6 reads 00000000.
